// File: rtl/fan_pid_scheduler.sv
// fan_pid_scheduler: divides the system clock into a PID update tick and a
// PWM clock enable, captures ADC samples and setpoints from a shared strobe
// bus, launches one PID update per tick and flags stale ADC data.
//
// Build option: define FANSEQ_EDGE_STROBE_EN to capture only on the rising
// edge of strobe_i (one capture per strobe pulse). Left undefined, every
// cycle with strobe_i high captures.
//
// Handshake with the PID datapath: pid_start_o is a one-cycle launch pulse
// (sent only from IDLE); the datapath answers with a one-cycle pid_done_i
// pulse, which is honoured only in BUSY. A tick that arrives while an update
// is outstanding is dropped and recorded in the sticky overrun_o flag.
module fan_pid_scheduler #(
    parameter int PID_CLK_DIV = 99_999,
    parameter int PWM_CLK_DIV = 13,
    parameter int STALE_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ena_i,
    input  logic [7:0] data_i,
    input  logic       strobe_i,
    input  logic       config_i,
    input  logic       pid_done_i,
    output logic       clk_en_PWM_o,
    output logic       pid_start_o,
    output logic [7:0] ADC_value_o,
    output logic [7:0] SET_value_o,
    output logic       failsafe_o,
    output logic       overrun_o,
    output logic [1:0] state_o
);

    localparam int PID_W = (PID_CLK_DIV > 0) ? $clog2(PID_CLK_DIV + 1) : 1;
    localparam int PWM_W = (PWM_CLK_DIV > 0) ? $clog2(PWM_CLK_DIV + 1) : 1;
    localparam logic [3:0] STALE_MAX = 4'(STALE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        BUSY  = 2'b10
    } state_t;

    logic [PID_W-1:0] pid_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic             pid_tick;
    logic             pwm_tick;
    logic             capture;
    logic [7:0]       adc_shadow;
    logic [7:0]       set_shadow;
    logic [3:0]       stale_q;
    logic [3:0]       stale_d;
    state_t           state_q;
    state_t           state_d;
    logic             start_pulse;

    assign pid_tick = (pid_cnt == PID_W'(PID_CLK_DIV));
    assign pwm_tick = (pwm_cnt == PWM_W'(PWM_CLK_DIV));

    // PID tick divider: free-running 0..PID_CLK_DIV, independent of ena_i
    always_ff @(posedge clk_i) begin
        if (rst_i || pid_tick) pid_cnt <= '0;
        else                   pid_cnt <= pid_cnt + 1'b1;
    end

    // PWM enable divider: free-running 0..PWM_CLK_DIV
    always_ff @(posedge clk_i) begin
        if (rst_i || pwm_tick) pwm_cnt <= '0;
        else                   pwm_cnt <= pwm_cnt + 1'b1;
    end

`ifdef FANSEQ_EDGE_STROBE_EN
    logic strobe_q;

    // Previous strobe level, used to detect the 0->1 transition
    always_ff @(posedge clk_i) begin
        if (rst_i) strobe_q <= 1'b0;
        else       strobe_q <= strobe_i;
    end

    assign capture = ena_i && strobe_i && !strobe_q;
`else
    assign capture = ena_i && strobe_i;
`endif

    // Shadow registers: config_i steers the bus to setpoint or ADC sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            adc_shadow <= 8'h00;
            set_shadow <= 8'h00;
        end else if (capture) begin
            if (config_i) set_shadow <= data_i;
            else          adc_shadow <= data_i;
        end
    end

    // Stale count: a fresh ADC capture beats a coincident tick
    always_comb begin
        stale_d = stale_q;
        if (capture && !config_i)               stale_d = 4'd0;
        else if (pid_tick && stale_q < STALE_MAX) stale_d = stale_q + 4'd1;
    end

    // Stale counter and failsafe flag registered from the same next value
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stale_q    <= 4'd0;
            failsafe_o <= 1'b0;
        end else begin
            stale_q    <= stale_d;
            failsafe_o <= (stale_d == STALE_MAX);
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and launch pulse; the unused encoding falls back to IDLE
    always_comb begin
        state_d     = IDLE;
        start_pulse = 1'b0;
        case (state_q)
            IDLE:    state_d = (pid_tick && ena_i) ? START : IDLE;
            START: begin
                start_pulse = 1'b1;
                state_d     = BUSY;
            end
            BUSY:    state_d = pid_done_i ? IDLE : BUSY;
            default: state_d = IDLE;
        endcase
    end

    // Snapshots load from the pre-update shadows while in START
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ADC_value_o <= 8'h00;
            SET_value_o <= 8'h00;
        end else if (state_q == START) begin
            ADC_value_o <= adc_shadow;
            SET_value_o <= set_shadow;
        end
    end

    // Sticky overrun: a tick landing on an outstanding update is dropped
    always_ff @(posedge clk_i) begin
        if (rst_i)                                  overrun_o <= 1'b0;
        else if (pid_tick && (state_q != IDLE))     overrun_o <= 1'b1;
    end

    assign clk_en_PWM_o = pwm_tick;
    assign pid_start_o  = start_pulse;
    assign state_o      = state_q;

endmodule

// File: tb/tb_fan_pid_scheduler.sv
// Bench for fan_pid_scheduler with small dividers. A cycle-indexed reference
// model predicts every output; directed scenarios add spot checks against
// fixed values, followed by a randomized run.
module tb_fan_pid_scheduler;

    localparam int PID_DIV = 9;
    localparam int PWM_DIV = 3;
    localparam int STALE   = 4;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       ena_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       strobe_i = 1'b0;
    logic       config_i = 1'b0;
    logic       pid_done_i = 1'b0;
    logic       clk_en_PWM_o;
    logic       pid_start_o;
    logic [7:0] ADC_value_o;
    logic [7:0] SET_value_o;
    logic       failsafe_o;
    logic       overrun_o;
    logic [1:0] state_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: cycle index since reset release plus abstract phase
    int         m_cyc   = 0;
    int         m_phase = 0;   // 0 idle, 1 launching, 2 waiting for done
    int         m_stale = 0;
    logic [7:0] m_adc_sh = 8'h00, m_set_sh = 8'h00;
    logic [7:0] m_adc_snap = 8'h00, m_set_snap = 8'h00;
    bit         m_over = 1'b0;
    bit         m_prev = 1'b0;

    fan_pid_scheduler #(
        .PID_CLK_DIV(PID_DIV),
        .PWM_CLK_DIV(PWM_DIV),
        .STALE_LIMIT(STALE)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ena_i(ena_i),
        .data_i(data_i),
        .strobe_i(strobe_i),
        .config_i(config_i),
        .pid_done_i(pid_done_i),
        .clk_en_PWM_o(clk_en_PWM_o),
        .pid_start_o(pid_start_o),
        .ADC_value_o(ADC_value_o),
        .SET_value_o(SET_value_o),
        .failsafe_o(failsafe_o),
        .overrun_o(overrun_o),
        .state_o(state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, m_cyc);
        end
    endtask

    // Advance the model across one rising edge with the given inputs
    task automatic model_edge(input logic rst, input logic ena, input logic stb,
                              input logic cfg, input logic [7:0] dat, input logic done);
        bit tick, cap, is_edge;
        if (rst) begin
            m_cyc = 0; m_phase = 0; m_stale = 0; m_over = 0; m_prev = 0;
            m_adc_sh = 0; m_set_sh = 0; m_adc_snap = 0; m_set_snap = 0;
            return;
        end
        tick = ((m_cyc % (PID_DIV + 1)) == PID_DIV);
`ifdef FANSEQ_EDGE_STROBE_EN
        is_edge = !m_prev;
`else
        is_edge = 1'b1;
`endif
        cap = ena && stb && is_edge;
        if (m_phase == 1) begin
            m_adc_snap = m_adc_sh;
            m_set_snap = m_set_sh;
        end
        if (tick && m_phase != 0) m_over = 1'b1;
        if (cap && !cfg)   m_stale = 0;
        else if (tick)     m_stale = (m_stale + 1 > STALE) ? STALE : m_stale + 1;
        if (cap) begin
            if (cfg) m_set_sh = dat;
            else     m_adc_sh = dat;
        end
        case (m_phase)
            0: m_phase = (tick && ena) ? 1 : 0;
            1: m_phase = 2;
            default: m_phase = done ? 0 : 2;
        endcase
        m_prev = stb;
        m_cyc++;
    endtask

    task automatic compare_all();
        check("clk_en_pwm", clk_en_PWM_o, (m_cyc % (PWM_DIV + 1)) == PWM_DIV);
        check("pid_start", pid_start_o, m_phase == 1);
        check("adc_value", ADC_value_o, m_adc_snap);
        check("set_value", SET_value_o, m_set_snap);
        check("failsafe", failsafe_o, m_stale == STALE);
        check("overrun", overrun_o, m_over);
        check("state", state_o, m_phase);
    endtask

    // Driver: apply inputs, cross one edge, compare at the falling edge
    task automatic step(input logic rst, input logic ena, input logic stb,
                        input logic cfg, input logic [7:0] dat, input logic done);
        rst_i = rst; ena_i = ena; strobe_i = stb;
        config_i = cfg; data_i = dat; pid_done_i = done;
        model_edge(rst, ena, stb, cfg, dat, done);
        @(posedge clk_i);
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Idle cycles, answering any outstanding update with done
    task automatic run_to_start();
        for (int i = 0; i < 40 && m_phase != 1; i++)
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, m_phase == 2);
        check("reach_start", pid_start_o, 1'b1);
    endtask

    initial begin
        int starts;
        @(negedge clk_i);

        // Reset state
        do_reset();
        check("rst_state", state_o, 2'b00);
        check("rst_adc", ADC_value_o, 8'h00);
        check("rst_overrun", overrun_o, 1'b0);

        // Launch cadence with done two cycles after each start
        for (int i = 0; i < 35; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, (m_cyc % 10) == 2);
            check("start_cadence", pid_start_o, (m_cyc == 10 || m_cyc == 20 || m_cyc == 30));
        end

        // Setpoint/ADC capture, and strobe coinciding with START
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0);
        run_to_start();
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
        check("snap_adc_40", ADC_value_o, 8'h40);
        check("snap_set_80", SET_value_o, 8'h80);
        run_to_start();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("snap_adc_55", ADC_value_o, 8'h55);

        // Failsafe after the fourth tick without samples
        do_reset();
        for (int i = 0; i < 39; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, m_phase == 2);
        check("failsafe_pre", failsafe_o, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, m_phase == 2);
        check("failsafe_set", failsafe_o, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h33, m_phase == 2);
        check("failsafe_clr", failsafe_o, 1'b0);

        // Overrun: no done across the next tick
        do_reset();
        run_to_start();
        starts = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            starts += pid_start_o;
        end
        check("overrun_set", overrun_o, 1'b1);
        check("no_queued_start", starts, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("done_to_idle", state_o, 2'b00);

        // Held strobe over five cycles
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h11 + 8'(i), 1'b0);
        run_to_start();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
`ifdef FANSEQ_EDGE_STROBE_EN
        check("held_strobe", ADC_value_o, 8'h11);
`else
        check("held_strobe", ADC_value_o, 8'h15);
`endif

        // Reset in BUSY, then a late done
        do_reset();
        run_to_start();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("in_busy", state_o, 2'b10);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("abandon_state", state_o, 2'b00);
        check("abandon_start", pid_start_o, 1'b0);
        check("abandon_adc", ADC_value_o, 8'h00);
        check("abandon_fs", failsafe_o, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("no_spurious", state_o, 2'b00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fan_pid_scheduler.md
FAN_PID_SCHEDULER -- requirements
Module: fan_pid_scheduler

Interface
REQ-001: Parameter PID_CLK_DIV, default 99_999: PID tick divider terminal count; tick period PID_CLK_DIV+1 clocks (100 Hz at 10 MHz).
REQ-002: Parameter PWM_CLK_DIV, default 13: PWM enable divider terminal count; period PWM_CLK_DIV+1 clocks.
REQ-003: Parameter STALE_LIMIT, default 4: PID ticks without a new ADC sample before failsafe asserts; legal range 1..15.
REQ-004: clk_i  input  1  single system clock; all logic on its rising edge.
REQ-005: rst_i  input  1  synchronous, active-high reset.
REQ-006: ena_i  input  1  design enable; low blocks captures and new PID cycles.
REQ-007: data_i  input  8  sample/setpoint data bus.
REQ-008: strobe_i  input  1  data-valid strobe.
REQ-009: config_i  input  1  1 = data_i is setpoint, 0 = data_i is ADC sample.
REQ-010: pid_done_i  input  1  one-cycle pulse from PID datapath: update finished.
REQ-011: clk_en_PWM_o  output  1  one-cycle PWM clock enable.
REQ-012: pid_start_o  output  1  one-cycle pulse launching one PID update.
REQ-013: ADC_value_o  output  8  ADC snapshot presented to PID.
REQ-014: SET_value_o  output  8  setpoint snapshot presented to PID.
REQ-015: failsafe_o  output  1  ADC data stale; fan must be forced to full speed.
REQ-016: overrun_o  output  1  sticky: a PID tick arrived while an update was still busy.
REQ-017: state_o  output  2  current FSM state encoding.

Function
REQ-018: PID and PWM dividers SHALL count 0..DIV and wrap to 0; tick/enable asserts exactly one cycle in the cycle the counter equals DIV.
REQ-019: With ena_i=1 and strobe capture, config_i=0 SHALL load data_i into ADC shadow, config_i=1 into SET shadow, next edge.
REQ-020: FSM states SHALL be IDLE(00), START(01), BUSY(10); 11 unused and SHALL recover to IDLE next cycle.
REQ-021: IDLE -> START on PID tick with ena_i=1; otherwise stay IDLE.
REQ-022: In START, pid_start_o SHALL be 1 for exactly that cycle, ADC_value_o/SET_value_o SHALL load from shadows; next state BUSY.
REQ-023: BUSY -> IDLE on pid_done_i; pid_done_i outside BUSY SHALL be ignored.
REQ-024: PID tick in START or BUSY SHALL set overrun_o and SHALL NOT queue a start.
REQ-025: Strobe and START in same cycle: snapshot SHALL take the pre-strobe shadow value; new value used at next START.
REQ-026: Stale counter (4 bits) SHALL increment on each PID tick, saturate at STALE_LIMIT, clear on ADC capture; ADC capture coincident with tick SHALL clear (capture wins).
REQ-027: failsafe_o SHALL equal (stale counter == STALE_LIMIT), registered.
REQ-028: ena_i low SHALL not stop dividers, stale counting, or an in-progress BUSY wait.
REQ-029: Snapshot outputs SHALL change only in START.

Reset
REQ-030: rst_i=1 at a rising edge SHALL clear both dividers, shadows, snapshots, stale counter, overrun_o; all outputs 0, state IDLE.
REQ-031: Reset mid-BUSY SHALL abandon the update; a later pid_done_i SHALL be ignored.
REQ-032: First PID tick SHALL occur PID_CLK_DIV+1 clocks after reset release.

Configuration
REQ-033: With FANSEQ_EDGE_STROBE_EN defined, capture SHALL occur only on the strobe_i 0->1 transition (one capture per strobe pulse; registered previous strobe reset to 0).
REQ-034: Without FANSEQ_EDGE_STROBE_EN, capture SHALL occur every cycle strobe_i is high.

Verification
REQ-035: PID_CLK_DIV=9, PWM_CLK_DIV=3, release reset -> pid_start_o at clocks 10,20,30 (with pid_done_i 2 cycles after each); clk_en_PWM_o every 4th clock.
REQ-036: strobe config=0 data 0x40, strobe config=1 data 0x80, tick -> START: ADC_value_o=0x40, SET_value_o=0x80.
REQ-037: No ADC strobes, STALE_LIMIT=4 -> failsafe_o=1 after 4th tick; one ADC strobe -> failsafe_o=0 next cycle.
REQ-038: Hold pid_done_i low over next tick -> overrun_o=1, no second pid_start_o; pid_done_i then returns IDLE.
REQ-039: strobe_i high 5 cycles, data 0x11..0x15 -> edge mode ADC shadow 0x11; level mode 0x15.
REQ-040: rst_i asserted in BUSY then pid_done_i pulse -> state IDLE, all outputs 0, no spurious start.
